// File: rtl/round_sequencer.sv
// Game-round controller for the roulette datapath.
// Collects a wager and up to four picked numbers, launches the wheel, scores the
// result, strobes the money manager and decides between continue / lose / win.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   bet_step, pick_valid,     betting controls (pulses), honoured only in BET
//   pick_num, bet_clear, spin
//   restart                   abort the game from any non-IDLE state
//   wheel_done, wheel_result  wheel completion pulse and winning number
//   current_money,            balance and balance flags from the money manager
//   money_zero, money_max
//   wheel_start               one-cycle wheel launch pulse
//   bet_amount, bet_count,    current wager, number of picks, packed picks
//   picks
//   hit_count, win_flag       scoring of the last spin
//   update_req                one-cycle balance update strobe
//   game_reset                one-cycle balance reinitialise pulse
//   state                     encoded FSM state
//   game_over, game_clear     lost / won indicators
//   timeout_err               sticky wheel-timeout indicator
module round_sequencer #(
  parameter int unsigned BET_STEP      = 10,
  parameter int unsigned BET_MAX       = 100,
  parameter int unsigned WHEEL_TIMEOUT = 1000000,
  parameter int unsigned SETTLE_CYC    = 2,
  parameter int unsigned RESULT_CYC    = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bet_step,
  input  logic        pick_valid,
  input  logic [3:0]  pick_num,
  input  logic        bet_clear,
  input  logic        spin,
  input  logic        restart,
  input  logic        wheel_done,
  input  logic [3:0]  wheel_result,
  input  logic [15:0] current_money,
  input  logic        money_zero,
  input  logic        money_max,
  output logic        wheel_start,
  output logic [15:0] bet_amount,
  output logic [2:0]  bet_count,
  output logic [15:0] picks,
  output logic [2:0]  hit_count,
  output logic        win_flag,
  output logic        update_req,
  output logic        game_reset,
  output logic [2:0]  state,
  output logic        game_over,
  output logic        game_clear,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StBet    = 3'd1,
    StSpin   = 3'd2,
    StUpdate = 3'd3,
    StSettle = 3'd4,
    StResult = 3'd5,
    StOver   = 3'd6,
    StClear  = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] bet_amount_q, bet_amount_d;
  logic [2:0]  bet_count_q, bet_count_d;
  logic [15:0] picks_q, picks_d;
  logic [2:0]  hit_count_q, hit_count_d;
  logic        win_flag_q, win_flag_d;
  logic        wheel_start_q, wheel_start_d;
  logic        update_req_q, update_req_d;
  logic        game_reset_q, game_reset_d;
  logic        timeout_err_q, timeout_err_d;

  logic [3:0]  slot_used;
  logic [2:0]  hits;
  logic        dup;
  logic [16:0] bet_sum;
  logic [16:0] bet_capped;

  // Slot compare against the wheel result and the offered pick; only filled slots count.
  always_comb begin
    hits = 3'd0;
    dup  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      slot_used[k] = (bet_count_q > 3'(k));
      if (slot_used[k] && (picks_q[4*k +: 4] == wheel_result)) hits = hits + 3'd1;
      if (slot_used[k] && (picks_q[4*k +: 4] == pick_num))     dup  = 1'b1;
    end
  end

  // 17-bit sum cannot wrap; saturate to the balance, then to the table ceiling.
  always_comb begin
    bet_sum    = {1'b0, bet_amount_q} + 17'(BET_STEP);
    bet_capped = bet_sum;
    if (bet_capped > {1'b0, current_money}) bet_capped = {1'b0, current_money};
    if (bet_capped > 17'(BET_MAX))          bet_capped = 17'(BET_MAX);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 32'd1;
    bet_amount_d  = bet_amount_q;
    bet_count_d   = bet_count_q;
    picks_d       = picks_q;
    hit_count_d   = hit_count_q;
    win_flag_d    = win_flag_q;
    wheel_start_d = 1'b0;
    update_req_d  = 1'b0;
    game_reset_d  = 1'b0;
    timeout_err_d = timeout_err_q;

    if (restart && (state_q != StIdle)) begin
      state_d      = StIdle;
      game_reset_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          bet_amount_d = '0;
          bet_count_d  = '0;
          picks_d      = '0;
          hit_count_d  = '0;
          win_flag_d   = 1'b0;
          state_d      = StBet;
        end
        StBet: begin
          if (spin && (bet_count_q != 3'd0) && (bet_amount_q != 16'd0)) begin
            wheel_start_d = 1'b1;
            timeout_err_d = 1'b0;
            state_d       = StSpin;
          end else if (bet_clear) begin
            bet_amount_d = '0;
            bet_count_d  = '0;
            picks_d      = '0;
          end else begin
            if (bet_step) bet_amount_d = bet_capped[15:0];
            if (pick_valid && (bet_count_q < 3'd4) && !dup) begin
              picks_d[{bet_count_q[1:0], 2'b00} +: 4] = pick_num;
              bet_count_d = bet_count_q + 3'd1;
            end
          end
        end
        StSpin: begin
          // A completion in the same cycle as the timeout takes precedence.
          if (wheel_done) begin
            hit_count_d  = hits;
            win_flag_d   = (hits != 3'd0);
            update_req_d = 1'b1;
            state_d      = StUpdate;
          end else if (cnt_q == WHEEL_TIMEOUT - 1) begin
            timeout_err_d = 1'b1;
            state_d       = StBet;
          end
        end
        StUpdate: state_d = StSettle;
        StSettle: begin
          if (cnt_q == SETTLE_CYC - 1) begin
            if (money_max)       state_d = StClear;
            else if (money_zero) state_d = StOver;
            else                 state_d = StResult;
          end
        end
        StResult: begin
          if (cnt_q == RESULT_CYC - 1) begin
            bet_amount_d = '0;
            bet_count_d  = '0;
            picks_d      = '0;
            hit_count_d  = '0;
            win_flag_d   = 1'b0;
            state_d      = StBet;
          end
        end
        StOver, StClear: ;
        default: state_d = StIdle;
      endcase
    end

    // Every state's dwell counter starts from zero on entry.
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bet_amount_q  <= '0;
      bet_count_q   <= '0;
      picks_q       <= '0;
      hit_count_q   <= '0;
      win_flag_q    <= 1'b0;
      wheel_start_q <= 1'b0;
      update_req_q  <= 1'b0;
      game_reset_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bet_amount_q  <= bet_amount_d;
      bet_count_q   <= bet_count_d;
      picks_q       <= picks_d;
      hit_count_q   <= hit_count_d;
      win_flag_q    <= win_flag_d;
      wheel_start_q <= wheel_start_d;
      update_req_q  <= update_req_d;
      game_reset_q  <= game_reset_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign wheel_start = wheel_start_q;
  assign bet_amount  = bet_amount_q;
  assign bet_count   = bet_count_q;
  assign picks       = picks_q;
  assign hit_count   = hit_count_q;
  assign win_flag    = win_flag_q;
  assign update_req  = update_req_q;
  assign game_reset  = game_reset_q;
  assign state       = state_q;
  assign game_over   = (state_q == StOver);
  assign game_clear  = (state_q == StClear);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed self-checking bench for round_sequencer with a scoring scoreboard.
module tb_round_sequencer;

  localparam int unsigned BET_STEP      = 10;
  localparam int unsigned BET_MAX       = 100;
  localparam int unsigned WHEEL_TIMEOUT = 20;
  localparam int unsigned SETTLE_CYC    = 2;
  localparam int unsigned RESULT_CYC    = 5;

  logic        clk = 1'b0;
  logic        rst, bet_step, pick_valid, bet_clear, spin, restart, wheel_done;
  logic [3:0]  pick_num, wheel_result;
  logic [15:0] current_money;
  logic        money_zero, money_max;
  logic        wheel_start, win_flag, update_req, game_reset, game_over, game_clear;
  logic        timeout_err;
  logic [15:0] bet_amount, picks;
  logic [2:0]  bet_count, hit_count, state;

  int errors = 0;
  int checks = 0;
  int upd_cnt = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;
  sb_item_t sb_q[$];

  round_sequencer #(
    .BET_STEP     (BET_STEP),
    .BET_MAX      (BET_MAX),
    .WHEEL_TIMEOUT(WHEEL_TIMEOUT),
    .SETTLE_CYC   (SETTLE_CYC),
    .RESULT_CYC   (RESULT_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bet_step     (bet_step),
    .pick_valid   (pick_valid),
    .pick_num     (pick_num),
    .bet_clear    (bet_clear),
    .spin         (spin),
    .restart      (restart),
    .wheel_done   (wheel_done),
    .wheel_result (wheel_result),
    .current_money(current_money),
    .money_zero   (money_zero),
    .money_max    (money_max),
    .wheel_start  (wheel_start),
    .bet_amount   (bet_amount),
    .bet_count    (bet_count),
    .picks        (picks),
    .hit_count    (hit_count),
    .win_flag     (win_flag),
    .update_req   (update_req),
    .game_reset   (game_reset),
    .state        (state),
    .game_over    (game_over),
    .game_clear   (game_clear),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (update_req) upd_cnt <= upd_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      it = sb_q.pop_front();
      chk(it.tag, obs, it.exp);
    end
  endtask

  task automatic do_step();
    bet_step = 1'b1; tick(); bet_step = 1'b0;
  endtask

  task automatic do_pick(input logic [3:0] n);
    pick_valid = 1'b1; pick_num = n; tick(); pick_valid = 1'b0;
  endtask

  task automatic do_clear();
    bet_clear = 1'b1; tick(); bet_clear = 1'b0;
  endtask

  task automatic do_spin();
    spin = 1'b1; tick(); spin = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1; tick(); restart = 1'b0;
  endtask

  // Finish a spin with the given result; scores are queued from the bench's own picks.
  task automatic finish_spin(input logic [3:0] res, input logic [2:0] exp_hits);
    sb_push("hit_count", 32'(exp_hits));
    sb_push("win_flag", 32'(exp_hits != 0));
    wheel_done = 1'b1; wheel_result = res; tick(); wheel_done = 1'b0;
    chk("update_req_high", 32'(update_req), 32'd1);
    sb_pop(32'(hit_count));
    sb_pop(32'(win_flag));
    tick();
    chk("update_req_single", 32'(update_req), 32'd0);
    chk("state_settle", 32'(state), 32'd4);
    repeat (SETTLE_CYC) tick();
  endtask

  initial begin
    int n;
    rst = 1'b1; bet_step = 0; pick_valid = 0; pick_num = 0; bet_clear = 0; spin = 0;
    restart = 0; wheel_done = 0; wheel_result = 0; current_money = 16'd100;
    money_zero = 0; money_max = 0;
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_bet_amount", 32'(bet_amount), 32'd0);
    chk("rst_picks", 32'(picks), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_update_req", 32'(update_req), 32'd0);
    rst = 1'b0;
    tick();
    chk("enter_bet", 32'(state), 32'd1);

    // Basic wager and pick collection with a duplicate dropped.
    repeat (3) do_step();
    do_pick(4'd5); do_pick(4'd5); do_pick(4'd9);
    chk("bet_amount_30", 32'(bet_amount), 32'd30);
    chk("bet_count_2", 32'(bet_count), 32'd2);
    chk("picks_95", 32'(picks[7:0]), 32'h95);

    // Saturation at balance, then at table ceiling.
    do_clear();
    chk("clear_amount", 32'(bet_amount), 32'd0);
    chk("clear_count", 32'(bet_count), 32'd0);
    current_money = 16'd45;
    repeat (12) do_step();
    chk("sat_money", 32'(bet_amount), 32'd45);
    do_clear();
    current_money = 16'd200;
    repeat (12) do_step();
    chk("sat_max", 32'(bet_amount), 32'(BET_MAX));

    // Spin without picks is rejected.
    do_spin();
    chk("spin_rej_start", 32'(wheel_start), 32'd0);
    chk("spin_rej_state", 32'(state), 32'd1);

    // Winning round.
    do_pick(4'd9); do_pick(4'd3);
    do_spin();
    chk("wheel_start", 32'(wheel_start), 32'd1);
    chk("state_spin", 32'(state), 32'd2);
    tick();
    chk("wheel_start_single", 32'(wheel_start), 32'd0);
    finish_spin(4'd9, 3'd1);
    chk("state_result", 32'(state), 32'd5);
    chk("result_amount_held", 32'(bet_amount), 32'd100);
    repeat (RESULT_CYC) tick();
    chk("result_to_bet", 32'(state), 32'd1);
    chk("result_cleared_amt", 32'(bet_amount), 32'd0);
    chk("result_cleared_hit", 32'(hit_count), 32'd0);
    chk("upd_cnt_1", 32'(upd_cnt), 32'd1);

    // Losing round into OVER, then restart.
    do_step(); do_pick(4'd4);
    do_spin(); tick();
    money_zero = 1'b1;
    finish_spin(4'd7, 3'd0);
    chk("state_over", 32'(state), 32'd6);
    chk("game_over", 32'(game_over), 32'd1);
    money_zero = 1'b0;
    do_restart();
    chk("restart_idle", 32'(state), 32'd0);
    chk("game_reset", 32'(game_reset), 32'd1);
    tick();
    chk("restart_bet", 32'(state), 32'd1);
    chk("game_reset_single", 32'(game_reset), 32'd0);
    chk("restart_picks", 32'(picks), 32'd0);
    chk("restart_count", 32'(bet_count), 32'd0);

    // Both flags at sample: cap wins.
    do_step(); do_pick(4'd1);
    do_spin(); tick();
    money_max = 1'b1; money_zero = 1'b1;
    finish_spin(4'd1, 3'd1);
    chk("state_clear", 32'(state), 32'd7);
    chk("game_clear", 32'(game_clear), 32'd1);
    money_max = 1'b0; money_zero = 1'b0;
    do_restart(); tick();
    chk("clear_restart_bet", 32'(state), 32'd1);
    chk("upd_cnt_3", 32'(upd_cnt), 32'd3);

    // Wheel timeout returns to BET with the bet retained.
    do_step(); do_pick(4'd2);
    do_spin();
    n = 0;
    while ((state == 3'd2) && (n < int'(WHEEL_TIMEOUT) + 5)) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'(WHEEL_TIMEOUT));
    chk("timeout_state", 32'(state), 32'd1);
    chk("timeout_err", 32'(timeout_err), 32'd1);
    chk("timeout_amount", 32'(bet_amount), 32'd10);
    chk("timeout_count", 32'(bet_count), 32'd1);
    chk("timeout_pick", 32'(picks[3:0]), 32'd2);
    chk("timeout_no_upd", 32'(upd_cnt), 32'd3);

    // Restart mid-SPIN.
    do_spin();
    chk("respin_clears_err", 32'(timeout_err), 32'd0);
    repeat (3) tick();
    do_restart();
    chk("abort_idle", 32'(state), 32'd0);
    tick();
    chk("abort_bet", 32'(state), 32'd1);
    chk("abort_no_upd", 32'(upd_cnt), 32'd3);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Game-round controller for the roulette datapath. It collects a player's bet (wager amount plus up to four picked numbers) and launches the wheel. It then scores the wheel result, drives the one-shot `update_req` handshake into the money manager, and decides after settlement whether play continues, is lost (balance 0) or is won (balance at cap). It sits between the button/debounce front end, the wheel animator and the money manager, and it sequences all three.

## Interface

Parameters:
- `BET_STEP`, 10: wager increment per `bet_step` pulse.
- `BET_MAX`, 100: wager ceiling.
- `WHEEL_TIMEOUT`, 1000000: cycles allowed in SPIN before abort.
- `SETTLE_CYC`, 2: wait cycles after `update_req` before sampling money flags.
- `RESULT_CYC`, 50000000: result display hold, in cycles.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `bet_step`, in, 1: one-cycle pulse; adds `BET_STEP` to the wager.
- `pick_valid`, in, 1: one-cycle pulse; `pick_num` is offered as a pick.
- `pick_num`, in, 4: number offered (0–15).
- `bet_clear`, in, 1: pulse; clears the wager and all picks.
- `spin`, in, 1: pulse; requests a spin.
- `restart`, in, 1: pulse; aborts the game and starts a new one.
- `wheel_done`, in, 1: pulse from the wheel; `wheel_result` is valid in the same cycle.
- `wheel_result`, in, 4: winning number.
- `current_money`, in, 16: balance from the money manager.
- `money_zero`, in, 1: balance == 0.
- `money_max`, in, 1: balance at cap.
- `wheel_start`, out, 1: one-cycle pulse that launches the wheel.
- `bet_amount`, out, 16: current wager.
- `bet_count`, out, 3: number of picks, 0–4.
- `picks`, out, 16: slot *k* occupies bits [4k+3:4k].
- `hit_count`, out, 3: picks matching `wheel_result`.
- `win_flag`, out, 1: `hit_count` != 0.
- `update_req`, out, 1: one-cycle balance-update strobe.
- `game_reset`, out, 1: one-cycle pulse that reinitialises the balance.
- `state`, out, 3: encoded FSM state.
- `game_over`, out, 1: high while in OVER.
- `game_clear`, out, 1: high while in CLEAR.
- `timeout_err`, out, 1: sticky wheel-timeout indicator.

## Operation

States: IDLE=0, BET=1, SPIN=2, UPDATE=3, SETTLE=4, RESULT=5, OVER=6, CLEAR=7.

Reset:
- `rst` forces IDLE.
- Every output resets to 0, including `picks`, `bet_amount` and `timeout_err`.
- Priority: `rst` > `restart` > all other inputs.

`restart` in any state other than IDLE goes to IDLE next cycle. This abort is allowed mid-SPIN and mid-SETTLE.

IDLE:
- `game_reset`=1 for exactly this one cycle.
- Clears the wager, picks, `hit_count` and `win_flag`.
- Goes to BET.

BET (all other inputs ignored outside BET):
- `bet_step`: `bet_amount` ← min(`bet_amount`+`BET_STEP`, `current_money`, `BET_MAX`). The sum is computed at 17 bits, so it never wraps.
- `pick_valid`: accepted only if `bet_count`<4 and `pick_num` is not already stored. The number goes into slot `bet_count`, then `bet_count`+1. Otherwise the pick is silently dropped.
- `bet_step` and `pick_valid` in the same cycle both take effect.
- `bet_clear` clears the wager and picks. It overrides a same-cycle step or pick.
- `spin` is accepted only if `bet_count`≥1 and `bet_amount`≥1. On acceptance:
  - `wheel_start`=1 for one cycle.
  - `timeout_err` clears and the timer resets.
  - Next state is SPIN.
  - A same-cycle step, pick or clear is ignored.
- A rejected `spin` has no effect.

SPIN:
- The wager and picks are frozen.
- On `wheel_done`:
  - Register `hit_count` = number of stored slots (index < `bet_count`) equal to `wheel_result`. This is 0 or 1, since duplicates are never stored.
  - Register `win_flag` = (`hit_count` != 0).
  - Go to UPDATE.
- If the timer reaches `WHEEL_TIMEOUT`-1 without `wheel_done`:
  - `timeout_err`←1.
  - Return to BET with the wager and picks retained; `update_req` is not issued.
- A `wheel_done` arriving in the same cycle as the timeout wins.

UPDATE: `update_req`=1 for exactly one cycle, then SETTLE. `bet_amount`, `bet_count`, `hit_count` and `win_flag` stay stable from UPDATE entry until RESULT exits.

SETTLE:
- Count `SETTLE_CYC` cycles.
- On the last cycle, sample the flags: `money_max` → CLEAR; else `money_zero` → OVER; else RESULT.
- `money_max` has priority if both flags are high.

RESULT:
- Hold for `RESULT_CYC` cycles.
- Then clear the wager, picks, `hit_count` and `win_flag`, and go to BET.

OVER and CLEAR: `game_over` or `game_clear` stays high until `restart` (→ IDLE).

## Timing

- `update_req` is a single-cycle pulse with at least `SETTLE_CYC`+`RESULT_CYC` low cycles between pulses. This meets the rising-edge detector downstream.
- Latencies:
  - `spin` accepted → `wheel_start` high in the next cycle (registered).
  - `wheel_done` at edge *n* → `update_req` high during cycle *n*+1.
  - Flags sampled at cycle *n*+1+`SETTLE_CYC`.
  - `game_over`/`game_clear`/RESULT asserted at cycle *n*+2+`SETTLE_CYC`.
- `restart` → `game_reset` pulse one cycle later, BET one cycle after that.
- All outputs are registered; no combinational input-to-output paths.

## Test plan

- Reset, then run with `current_money`=100, 3 × `bet_step` and picks 5, 5, 9 → `bet_amount`=30, `bet_count`=2, `picks`[7:0]=0x95; the duplicate 5 is dropped.
- `bet_step` ×12 with `current_money`=45 → `bet_amount` saturates at 45. With `current_money`=200 it saturates at `BET_MAX`=100.
- `spin` with `bet_count`=0 → no `wheel_start`, stays in BET. Valid `spin` → one `wheel_start` pulse; `wheel_done` with result 9 → `hit_count`=1, `win_flag`=1, single `update_req`, SETTLE, then RESULT.
- Loss with `money_zero` driven high during SETTLE → OVER, `game_over`=1. `restart` → one `game_reset` pulse, then BET with everything cleared.
- `money_max` and `money_zero` both high at sample → CLEAR, `game_clear`=1.
- No `wheel_done` for `WHEEL_TIMEOUT` cycles → BET, `timeout_err`=1, wager and picks retained, `update_req` never asserted. A `restart` mid-SPIN → IDLE, no `update_req`.
